// File: rtl/general_multiplier_if.sv
// Operand/result handshake bundle for the shift-add multiply-accumulate unit.
interface general_multiplier_if #(
  parameter int WIDTH_A = 4,
  parameter int WIDTH_B = 4
);
  logic                       start;
  logic [WIDTH_A-1:0]         Q;
  logic [WIDTH_B-1:0]         B;
  logic [WIDTH_B-1:0]         R;
  logic [WIDTH_A+WIDTH_B-1:0] P;
  logic                       busy;
  logic                       done;

  modport master (output start, Q, B, R, input P, busy, done);
  modport slave  (input start, Q, B, R, output P, busy, done);
endinterface

// File: rtl/general_multiplier.sv
// Sequential shift-add multiply-accumulate, P = Q*B + R, one partial product per clock.
// state | meaning
// IDLE  | waiting for start, outputs quiet
// RUN   | WIDTH_A partial-product steps, P shows partial sums
// DONE  | result valid on P, start reloads and re-runs
module general_multiplier #(
  parameter int WIDTH_A = 4,
  parameter int WIDTH_B = 4
) (
  input logic clk,
  input logic reset,
  general_multiplier_if.slave bus
);
  localparam int W  = WIDTH_A + WIDTH_B;
  localparam int CW = $clog2(WIDTH_A + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH_A - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [W-1:0]       acc, mcand;
  logic [WIDTH_A-1:0] qreg;
  logic [CW-1:0]      cnt;
  logic               load, step, busy, done;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sum cannot exceed 2^WA*(2^WB-1), so the W-bit accumulator never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      mcand <= '0;
      qreg  <= '0;
      cnt   <= '0;
    end else if (load) begin
      acc   <= {{WIDTH_A{1'b0}}, bus.R};
      mcand <= {{WIDTH_A{1'b0}}, bus.B};
      qreg  <= bus.Q;
      cnt   <= '0;
    end else if (step) begin
      if (qreg[0]) acc <= acc + mcand;
      mcand <= mcand << 1;
      qreg  <= qreg >> 1;
      cnt   <= cnt + 1'b1;
    end
  end

  assign bus.P    = acc;
  assign bus.busy = busy;
  assign bus.done = done;
endmodule

// File: tb/tb_general_multiplier.sv
// Directed and randomized checks of general_multiplier against P = Q*B + R.
module tb_general_multiplier;
  localparam int WA = 4;
  localparam int WB = 4;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc;

  general_multiplier_if #(.WIDTH_A(WA), .WIDTH_B(WB)) bus ();

  general_multiplier #(.WIDTH_A(WA), .WIDTH_B(WB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic drive(input int q, input int b, input int r);
    bus.Q = q[WA-1:0];
    bus.B = b[WB-1:0];
    bus.R = r[WB-1:0];
  endtask

  // Full operation from an idle/done state; reference result is plain arithmetic.
  task automatic run_op(input string tag, input int q, input int b, input int r);
    int n;
    drive(q, b, r);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    wait_done(n);
    chk({tag, "_lat"}, 32'(n), 32'd4);
    chk({tag, "_P"}, 32'(bus.P), 32'(q * b + r));
  endtask

  initial begin
    int q, b, r, n;
    reset = 1'b1;
    bus.start = 1'b0;
    drive(0, 0, 0);
    tick();
    tick();
    chk("rst_P", 32'(bus.P), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    reset = 1'b0;
    tick();

    run_op("basic", 13, 11, 7);
    chk("basic_abs", 32'(bus.P), 32'd150);
    drive(1, 1, 1);
    tick(); tick(); tick();
    chk("hold_done", 32'(bus.done), 32'd1);
    chk("hold_P", 32'(bus.P), 32'd150);

    run_op("max", 15, 15, 15);
    chk("max_abs", 32'(bus.P), 32'd240);
    run_op("q0", 0, 9, 5);
    run_op("b0", 15, 0, 0);

    for (int a = 0; a < 16; a++) begin
      for (int d = 1; d < 16; d++) begin
        drive(a / d, d, a % d);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(n);
        chk("rt_P", 32'(bus.P), 32'(a));
      end
    end

    for (int i = 0; i < 30; i++) begin
      q = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      r = int'($urandom_range(0, 15));
      run_op("rand", q, b, r);
    end

    // start with new operands during RUN must not disturb the result
    drive(5, 6, 3);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    drive(2, 2, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(n);
    chk("ign_lat", 32'(n), 32'd2);
    chk("ign_P", 32'(bus.P), 32'd33);
    tick();
    chk("ign_stay", 32'(bus.done), 32'd1);

    // start held across DONE
    drive(7, 9, 2);
    bus.start = 1'b1;
    tick();
    drive(3, 5, 1);
    wait_done(n);
    chk("held_lat1", 32'(n), 32'd4);
    chk("held_P1", 32'(bus.P), 32'd65);
    tick();
    chk("held_done_pulse", 32'(bus.done), 32'd0);
    chk("held_busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    wait_done(n);
    chk("held_lat2", 32'(n), 32'd4);
    chk("held_P2", 32'(bus.P), 32'd16);

    // reset on the second RUN cycle
    drive(13, 11, 7);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("mid_busy", 32'(bus.busy), 32'd0);
    chk("mid_done", 32'(bus.done), 32'd0);
    chk("mid_P", 32'(bus.P), 32'd0);
    reset = 1'b0;
    run_op("after_rst", 9, 12, 10);

    // reset and start on the same edge
    drive(6, 7, 4);
    reset = 1'b1;
    bus.start = 1'b1;
    tick();
    chk("col_busy", 32'(bus.busy), 32'd0);
    chk("col_done", 32'(bus.done), 32'd0);
    chk("col_P", 32'(bus.P), 32'd0);
    reset = 1'b0;
    tick();
    bus.start = 1'b0;
    chk("col_acc", 32'(bus.busy), 32'd1);
    wait_done(n);
    chk("col_lat", 32'(n), 32'd4);
    chk("col_P2", 32'(bus.P), 32'd46);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/general_multiplier.md
# general_multiplier

Sequential shift-add multiply-accumulate unit computing P = Q*B + R. It is the inverse of `general_divider`: feeding the divider's quotient, divisor and remainder back in reconstructs the original dividend. The unit takes one partial-product step per clock, has a fixed latency and a start/busy/done handshake, and serves as the reconstruction and check path beside the divider.

## Interface
- WIDTH_A, 4, width of multiplier operand Q (same meaning as the divider's dividend width); ≥1
- WIDTH_B, 4, width of multiplicand B and addend R; ≥1
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset, sampled on rising edge of clk
- start  in  1  request; sampled only when not busy
- Q  in  WIDTH_A  multiplier (quotient); captured when start is accepted
- B  in  WIDTH_B  multiplicand (divisor); captured when start is accepted
- R  in  WIDTH_B  addend (remainder); captured when start is accepted
- P  out  WIDTH_A+WIDTH_B  result Q*B+R; valid only while done=1
- busy  out  1  high while the computation is in progress
- done  out  1  level; high from completion until the next accepted start or reset

## Operation
- Internal registers:
  - acc [WIDTH_A+WIDTH_B]
  - mcand [WIDTH_A+WIDTH_B]
  - qreg [WIDTH_A]
  - cnt [$clog2(WIDTH_A+1)]
  - state
- P is driven directly from acc.
- States IDLE, RUN, DONE.
  - IDLE: busy=0, done=0. If start=1, go to RUN and load:
    - acc ← zero-extended R
    - mcand ← zero-extended B
    - qreg ← Q
    - cnt ← 0
  - RUN: busy=1, done=0. Each cycle:
    - if qreg[0], acc ← acc + mcand (modulo 2^(WIDTH_A+WIDTH_B)); otherwise acc is unchanged
    - mcand ← mcand<<1
    - qreg ← qreg>>1
    - cnt ← cnt+1
    - when cnt == WIDTH_A-1, go to DONE on this same edge
  - DONE: busy=0, done=1, P holds its value. If start=1, reload the operands exactly as in IDLE and go to RUN; done drops on that edge.
- start is ignored in RUN; the operand inputs are don't-care outside the accepting edge.
- Width rule: the maximum result is (2^WA-1)(2^WB-1)+(2^WB-1) = 2^WA(2^WB-1) < 2^(WA+WB). No overflow or carry-out is possible, so no extra bit is needed.
- There is no early termination: latency is fixed regardless of operand values, including Q=0.
- Reset has priority over everything, including during RUN, where it aborts the computation with no partial result retained. Reset drives:
  - state=IDLE
  - busy=0, done=0
  - acc=0, so P=0
  - mcand=0, qreg=0, cnt=0

## Timing
- Reset values: P=0, busy=0, done=0.
- Start is accepted on edge k (state IDLE or DONE, start=1, reset=0).
  - busy=1 after edge k.
  - Steps execute on edges k+1 … k+WIDTH_A.
  - After edge k+WIDTH_A: busy=0, done=1, P valid.
  - Latency from accepting edge to done is WIDTH_A cycles; throughput is one operation per WIDTH_A+1 cycles when start is held high.
- WIDTH_A=1: exactly one RUN cycle.
- During RUN, P shows partial sums and must not be sampled.
- start held high continuously: re-accepted on the first DONE cycle. done is high for exactly one cycle, then the next operation begins.
- reset and start both high on the same edge: reset wins, state=IDLE.
- Reset deasserted with start already high: start is accepted on the first edge where reset=0.

## Test plan
All scenarios use WIDTH_A=4, WIDTH_B=4.
- Basic: Q=13, B=11, R=7, one-cycle start pulse -> busy for 4 cycles, then done=1, P=150; P and done hold until the next start.
- Corners:
  - Q=15, B=15, R=15 -> P=240, no wrap.
  - Q=0, B=9, R=5 -> P=5 after 4 cycles.
  - Q=15, B=0, R=0 -> P=0.
- Divider round trip: general_divider(A=13, B=3) gives Q=4, R=1. Feed Q=4, B=3, R=1 -> P=13. Sweep all A in 0..15 with B in 1..15 and require P==A every time.
- Busy/back-to-back:
  - Pulse start with different operands (Q=2, B=2, R=0) during RUN -> ignored; the first result completes unchanged.
  - start held high across DONE -> done high for exactly 1 cycle, then the new result Q=3, B=5, R=1 -> P=16.
- Reset mid-operation: assert reset on RUN cycle 2 -> next cycle busy=0, done=0, P=0. A new start then gives a correct result with normal latency.
- Reset/start collision: reset=1 and start=1 on the same edge -> IDLE, busy=0. Release reset with start still high -> accepted on the next edge, done after 4 cycles.
